// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the EX-stage branch controller: FSM states and
// RISC-V conditional-branch funct3 codes.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // The only holes in the branch funct3 space are 010 and 011.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Pure combinational branch-condition evaluator, shared by pipeline variants.
module br_cmp
    import branch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    output logic                  taken_o,
    output logic                  illegal_o
);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = ~f3_is_legal(funct3_i);
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage conditional-branch controller: operand wait, resolution, mispredict
// redirect/flush sequencing and branch/mispredict event counters.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [2:0]            br_funct3,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic [ADDR_WIDTH-1:0] br_imm,
    input  logic                  br_pred_taken,
    input  logic                  opnd_ready,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  kill,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic                  illegal_br,
    output logic [31:0]           br_count,
    output logic [31:0]           mispred_count
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH-1:0]   pc_q, imm_q;
    logic                    pred_q;
    logic                    redirect_valid_q, illegal_q;
    logic [ADDR_WIDTH-1:0]   redirect_pc_q;
    logic [31:0]             br_count_q, mispred_count_q;

    logic                    in_idle, in_wait, accept, resolve;
    logic [2:0]              sel_funct3;
    logic [ADDR_WIDTH-1:0]   sel_pc, sel_imm, target;
    logic                    sel_pred, taken, illegal, mispredict;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_wait  = (state_q == ST_WAIT);
    assign br_ready = in_idle & ~kill;
    assign accept   = br_valid & br_ready;

    // In WAIT the branch fields come from the latch; upstream may have moved on.
    assign sel_funct3 = in_wait ? funct3_q : br_funct3;
    assign sel_pc     = in_wait ? pc_q     : br_pc;
    assign sel_imm    = in_wait ? imm_q    : br_imm;
    assign sel_pred   = in_wait ? pred_q   : br_pred_taken;

    br_cmp #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
        .funct3_i  (sel_funct3),
        .rs1_i     (rs1_data),
        .rs2_i     (rs2_data),
        .taken_o   (taken),
        .illegal_o (illegal)
    );

    assign resolve    = (accept | in_wait) & opnd_ready & ~kill;
    assign mispredict = (taken != sel_pred);
    assign target     = taken ? (sel_pc + sel_imm) : (sel_pc + ADDR_WIDTH'(4));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!opnd_ready)     state_d = ST_WAIT;
                    else if (mispredict) state_d = ST_REDIRECT;
                end
            end
            ST_WAIT: begin
                if (opnd_ready) state_d = mispredict ? ST_REDIRECT : ST_IDLE;
            end
            ST_REDIRECT: begin
                if (flush_cnt_q == CNT_W'(FLUSH_CYCLES - 1)) state_d = ST_IDLE;
                else flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= '0;
            funct3_q         <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            pred_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            illegal_q        <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= resolve & mispredict;
            illegal_q        <= resolve & illegal;
            if (accept) begin
                funct3_q <= br_funct3;
                pc_q     <= br_pc;
                imm_q    <= br_imm;
                pred_q   <= br_pred_taken;
            end
            if (resolve) br_count_q <= br_count_q + 32'd1;
            // redirect_pc only moves on a real mispredict so it stays stable through the flush.
            if (resolve && mispredict) begin
                redirect_pc_q   <= target;
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign stall          = in_wait & ~opnd_ready;
    assign flush          = (state_q == ST_REDIRECT);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign illegal_br     = illegal_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

endmodule
